game_event_manager: RTL

GAME_EVENT_MANAGER -- requirements
Module: game_event_manager

---
 rtl/game_event_manager.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/game_event_manager.sv
// Game event manager: turns per-pixel collision strobes into one event per
// frame, keeps score and lives, and sequences IDLE/PLAY/DYING/GAME_OVER.
// Handshake: none; startOfFrame is a one-cycle strobe, and every *_pulse and
// respawn output is high for exactly one clk, one cycle after the strobe that
// produced it.
module game_event_manager #(
  parameter int INIT_LIVES   = 3,
  parameter int GOLD_POINTS  = 500,
  parameter int ALIEN_POINTS = 250,
  parameter int DEATH_FRAMES = 60,
  parameter int SCORE_MAX    = 9999
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic        start_game,
  input  logic        collision_player_terrain,
  input  logic        colision_fire,
  input  logic        player_eat_gold_1,
  input  logic        player_died,
  input  logic        alien_died_a,
  output logic [1:0]  game_state,
  output logic        player_awake,
  output logic [15:0] score,
  output logic [2:0]  lives,
  output logic        dig_pulse,
  output logic        shot_hit_pulse,
  output logic        gold_pulse,
  output logic        alien_pulse,
  output logic        death_pulse,
  output logic        respawn
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLAY  = 2'd1,
    S_DYING = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  localparam logic [2:0]  INIT_L   = 3'(INIT_LIVES);
  localparam logic [17:0] GOLD_W   = 18'(GOLD_POINTS);
  localparam logic [17:0] ALIEN_W  = 18'(ALIEN_POINTS);
  localparam logic [17:0] MAX_W    = 18'(SCORE_MAX);
  localparam logic [7:0]  LAST_CNT = 8'(DEATH_FRAMES - 1);

  // Event bit order shared by latches and pulses:
  // 0 dig, 1 shot, 2 gold, 3 alien, 4 died
  logic [4:0]  hit;
  state_t      state_q, state_d;
  logic [4:0]  latch_q, latch_d;
  logic [4:0]  pulse_q, pulse_d;
  logic        respawn_q, respawn_d;
  logic [15:0] score_q, score_d;
  logic [2:0]  lives_q, lives_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [17:0] sum;

  assign hit = {player_died, alien_died_a, player_eat_gold_1,
                colision_fire, collision_player_terrain};

  // Next-state: latch accumulation, frame evaluation, scoring and FSM
  always_comb begin
    state_d   = state_q;
    latch_d   = latch_q | hit;
    pulse_d   = '0;
    respawn_d = 1'b0;
    score_d   = score_q;
    lives_d   = lives_q;
    cnt_d     = cnt_q;
    sum       = {2'b00, score_q} + (latch_q[2] ? GOLD_W : 18'd0)
                                 + (latch_q[3] ? ALIEN_W : 18'd0);
    // Latches hand their contents to evaluation; same-cycle hits start the next frame
    if (startOfFrame) latch_d = hit;
    case (state_q)
      S_IDLE, S_OVER: begin
        if (start_game) begin
          state_d = S_PLAY;
          score_d = '0;
          lives_d = INIT_L;
          latch_d = '0;
        end
      end
      S_PLAY: begin
        if (startOfFrame) begin
          pulse_d = latch_q;
          score_d = (sum > MAX_W) ? MAX_W[15:0] : sum[15:0];
          if (latch_q[4]) begin
            lives_d = lives_q - 3'd1;
            if (lives_q == 3'd1) begin
              state_d = S_OVER;
            end else begin
              state_d = S_DYING;
              cnt_d   = '0;
            end
          end
        end
      end
      S_DYING: begin
        if (startOfFrame) begin
          if (cnt_q == LAST_CNT) begin
            state_d   = S_PLAY;
            respawn_d = 1'b1;
            latch_d   = '0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      latch_q   <= '0;
      pulse_q   <= '0;
      respawn_q <= 1'b0;
      score_q   <= '0;
      lives_q   <= INIT_L;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      latch_q   <= latch_d;
      pulse_q   <= pulse_d;
      respawn_q <= respawn_d;
      score_q   <= score_d;
      lives_q   <= lives_d;
      cnt_q     <= cnt_d;
    end
  end

  assign game_state     = state_q;
  assign player_awake   = (state_q == S_PLAY);
  assign score          = score_q;
  assign lives          = lives_q;
  assign dig_pulse      = pulse_q[0];
  assign shot_hit_pulse = pulse_q[1];
  assign gold_pulse     = pulse_q[2];
  assign alien_pulse    = pulse_q[3];
  assign death_pulse    = pulse_q[4];
  assign respawn        = respawn_q;

endmodule
